// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR sequence generator.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] TAPS_32 = 32'hA300_0000;
  localparam logic [31:0] SEED_32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR that advances BPC steps per enabled cycle.
// A zero seed is replaced by SEED_DEFAULT, and the replacement is flagged.
module lfsr_core #(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = 32'hA300_0000,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = '1,
  parameter int                BPC          = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [BPC-1:0]    o_bits,
  output logic              o_zero_err
);

  logic [LFSR_W-1:0] r_state;
  logic              r_zero_err;
  logic [LFSR_W-1:0] w_chain [BPC+1];
  logic [BPC-1:0]    w_bits;
  logic              w_seed_zero;

  // Steps are chained within the cycle; the earliest bit lands in the MSB of o_bits.
  always_comb begin
    w_bits     = '0;
    w_chain[0] = r_state;
    for (int i = 0; i < BPC; i++) begin
      w_bits[BPC-1-i] = ^(w_chain[i] & TAPS);
      w_chain[i+1]    = {w_chain[i][LFSR_W-2:0], w_bits[BPC-1-i]};
    end
  end

  assign w_seed_zero = (i_seed == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SEED_DEFAULT;
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= i_load && w_seed_zero;
      if (i_load)
        r_state <= w_seed_zero ? SEED_DEFAULT : i_seed;
      else if (i_step)
        r_state <= w_chain[BPC];
    end
  end

  assign o_bits     = w_bits;
  assign o_zero_err = r_zero_err;

endmodule

// File: rtl/lfsr_seq_gen.sv
// Assembles SEQ_W LFSR bits into one sequence and presents it to the consumer.
// The sequence is held with a valid/ready handshake.
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(TAPS_32),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = '1,
  parameter int                SEQ_W        = 256,
  parameter int                BPC          = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              start,
  input  logic              en,
  output logic              busy,
  output logic              seq_valid,
  input  logic              seq_ready,
  output logic [SEQ_W-1:0]  seq_out,
  output logic              seed_zero_err
);

  localparam int NSTEP = SEQ_W / BPC;
  localparam int CNT_W = $clog2(NSTEP + 1);

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [SEQ_W-1:0] r_shift;
  logic             w_load, w_step;
  logic [BPC-1:0]   w_bits;

  lfsr_core #(
    .LFSR_W       (LFSR_W),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT),
    .BPC          (BPC)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_seed     (seed_in),
    .i_step     (w_step),
    .o_bits     (w_bits),
    .o_zero_err (seed_zero_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = seed_load;
        if (start) w_nxt = GEN;
      end
      GEN: begin
        w_step = en;
        if (en && r_cnt == CNT_W'(1)) w_nxt = HOLD;
      end
      HOLD: if (seq_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (r_state == IDLE && start) begin
      r_cnt   <= CNT_W'(NSTEP);
      r_shift <= '0;
    end else if (w_step) begin
      r_cnt   <= r_cnt - CNT_W'(1);
      r_shift <= (r_shift << BPC) | SEQ_W'(w_bits);
    end
  end

  assign busy      = (r_state != IDLE);
  assign seq_valid = (r_state == HOLD);
  assign seq_out   = seq_valid ? r_shift : '0;

endmodule
